// File: rtl/way_rr_arbiter_pkg.sv
// Shared cache selector definitions: index-width derivation and arbitration mode constants.
package way_rr_arbiter_pkg;

  localparam bit MODE_FIXED = 1'b0;
  localparam bit MODE_RR    = 1'b1;

  // An index is always at least one bit wide, even for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/way_rr_arbiter_ff_lsb_encode.sv
// Combinational find-first encoder: lowest set bit as one-hot and as binary index.
module ff_lsb_encode import way_rr_arbiter_pkg::*; #(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic [N-1:0]     oh_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;

  always_comb begin
    oh_o  = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i] && !found) begin
        found   = 1'b1;
        oh_o[i] = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/way_rr_arbiter.sv
// Registered one-hot/index selector with fixed-priority or round-robin policy
// behind a valid/ready output register.
module way_rr_arbiter import way_rr_arbiter_pkg::*; #(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N),
  parameter bit RR    = MODE_RR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic             accept, load;
  logic [IDX_W-1:0] ptr_q, ptr_d, ptr_adv, eff_ptr, sel_ptr;
  logic [N-1:0]     rot, enc_oh, win_oh;
  logic [IDX_W-1:0] enc_idx, win_idx;
  logic             enc_any;
  int               win_sum;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

  assign accept = out_valid_q & out_ready;
  assign load   = !out_valid_q | out_ready;

  // Explicit wrap at N; a plain increment would overflow into unused codes for non-power-of-two N.
  assign ptr_adv = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  assign eff_ptr = accept ? ptr_adv : ptr_q;
  assign sel_ptr = RR ? eff_ptr : '0;
  assign ptr_d   = accept ? ptr_adv : ptr_q;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == (i + int'(sel_ptr)) % N) rot[i] = req[j];
      end
    end
  end

  ff_lsb_encode #(.N(N), .IDX_W(IDX_W)) u_enc (
    .vec_i (rot),
    .oh_o  (enc_oh),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Undo the rotation on the index, then rebuild the one-hot from it.
  always_comb begin
    win_sum = int'(enc_idx) + int'(sel_ptr);
    if (win_sum >= N) win_sum = win_sum - N;
    win_idx = IDX_W'(win_sum);
    win_oh  = '0;
    for (int i = 0; i < N; i++) win_oh[i] = (win_idx == IDX_W'(i));
    if (sel_ptr == '0) win_oh = enc_oh;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    if (load) begin
      out_valid_d = enc_any;
      grant_oh_d  = enc_any ? win_oh  : '0;
      grant_idx_d = enc_any ? win_idx : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign grant_oh  = grant_oh_q;
  assign grant_idx = grant_idx_q;
  assign any_req   = |req;

endmodule

// File: tb/tb_way_rr_arbiter.sv
// Directed bench for way_rr_arbiter: round-robin N=4, round-robin N=3 and fixed-priority N=4.
module tb_way_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] req4 = '0;
  logic       rdy4 = 1'b0;
  logic       vld4;
  logic [3:0] oh4;
  logic [1:0] idx4;
  logic       any4;

  logic [2:0] req3 = '0;
  logic       rdy3 = 1'b0;
  logic       vld3;
  logic [2:0] oh3;
  logic [1:0] idx3;
  logic       any3;

  logic [3:0] req0 = '0;
  logic       rdy0 = 1'b0;
  logic       vld0;
  logic [3:0] oh0;
  logic [1:0] idx0;
  logic       any0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  way_rr_arbiter #(.N(4), .RR(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(rdy4),
    .out_valid(vld4), .grant_oh(oh4), .grant_idx(idx4), .any_req(any4)
  );

  way_rr_arbiter #(.N(3), .RR(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .out_ready(rdy3),
    .out_valid(vld3), .grant_oh(oh3), .grant_idx(idx3), .any_req(any3)
  );

  way_rr_arbiter #(.N(4), .RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .out_ready(rdy0),
    .out_valid(vld0), .grant_oh(oh0), .grant_idx(idx0), .any_req(any0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    rst_n = 1'b1;
    req4 = 4'b0100;
    rdy4 = 1'b0;
    step();
    total++;
    if ({vld4, oh4, idx4} !== {1'b1, 4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL reset_pre_grant got v=%0b oh=%b idx=%0d want v=1 oh=0100 idx=2", vld4, oh4, idx4);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({vld4, oh4, idx4, dut4.ptr_q} !== {1'b0, 4'b0000, 2'd0, 2'd0}) begin
      bad++;
      $display("FAIL reset_async got v=%0b oh=%b idx=%0d ptr=%0d want all 0", vld4, oh4, idx4, dut4.ptr_q);
    end
    #2 rst_n = 1'b1;
    req4 = 4'b1000;
    rdy4 = 1'b1;
    step();
    total++;
    if ({vld4, oh4, idx4} !== {1'b1, 4'b1000, 2'd3}) begin
      bad++;
      $display("FAIL reset_first_grant got v=%0b oh=%b idx=%0d want v=1 oh=1000 idx=3", vld4, oh4, idx4);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_idx [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] exp_oh;
    req4 = 4'b0000;
    step();
    total++;
    if ({vld4, dut4.ptr_q} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL idle_after_idx3 got v=%0b ptr=%0d want v=0 ptr=0", vld4, dut4.ptr_q);
    end
    req4 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_oh = 4'b0001 << exp_idx[k];
      total++;
      if ({vld4, oh4, idx4} !== {1'b1, exp_oh, exp_idx[k]}) begin
        bad++;
        $display("FAIL rr_seq[%0d] got v=%0b oh=%b idx=%0d want v=1 oh=%b idx=%0d",
                 k, vld4, oh4, idx4, exp_oh, exp_idx[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    req4 = 4'b0001;
    step();
    req4 = 4'b0000;
    step();
    total++;
    if ({vld4, dut4.ptr_q} !== {1'b0, 2'd1}) begin
      bad++;
      $display("FAIL bp_setup got v=%0b ptr=%0d want v=0 ptr=1", vld4, dut4.ptr_q);
    end
    req4 = 4'b0110;
    rdy4 = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({vld4, oh4, idx4} !== {1'b1, 4'b0010, 2'd1}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%0b oh=%b idx=%0d want v=1 oh=0010 idx=1", k, vld4, oh4, idx4);
      end
      req4 = (k < 1) ? 4'b1000 : 4'b0000;
      if (k < 4) step();
    end
    total++;
    if (any4 !== 1'b0) begin
      bad++;
      $display("FAIL bp_any_req got %0b want 0", any4);
    end
    req4 = 4'b1010;
    rdy4 = 1'b1;
    step();
    rdy4 = 1'b0;
    total++;
    if ({vld4, oh4, idx4, dut4.ptr_q} !== {1'b1, 4'b1000, 2'd3, 2'd2}) begin
      bad++;
      $display("FAIL bp_release got v=%0b oh=%b idx=%0d ptr=%0d want v=1 oh=1000 idx=3 ptr=2",
               vld4, oh4, idx4, dut4.ptr_q);
    end
  endtask

  task automatic test_wrap();
    req4 = 4'b1001;
    rdy4 = 1'b1;
    step();
    total++;
    if ({idx4, oh4, dut4.ptr_q} !== {2'd0, 4'b0001, 2'd0}) begin
      bad++;
      $display("FAIL wrap_ptr0 got idx=%0d oh=%b ptr=%0d want idx=0 oh=0001 ptr=0", idx4, oh4, dut4.ptr_q);
    end
    req4 = 4'b0100;
    step();
    req4 = 4'b0000;
    step();
    total++;
    if ({vld4, dut4.ptr_q} !== {1'b0, 2'd3}) begin
      bad++;
      $display("FAIL wrap_ptr3_setup got v=%0b ptr=%0d want v=0 ptr=3", vld4, dut4.ptr_q);
    end
    req4 = 4'b1001;
    step();
    total++;
    if ({vld4, idx4} !== {1'b1, 2'd3}) begin
      bad++;
      $display("FAIL wrap_ptr3_1001 got v=%0b idx=%0d want v=1 idx=3", vld4, idx4);
    end
    req4 = 4'b0100;
    step();
    req4 = 4'b0000;
    step();
    req4 = 4'b0011;
    step();
    total++;
    if ({vld4, oh4, idx4} !== {1'b1, 4'b0001, 2'd0}) begin
      bad++;
      $display("FAIL wrap_ptr3_0011 got v=%0b oh=%b idx=%0d want v=1 oh=0001 idx=0", vld4, oh4, idx4);
    end
  endtask

  task automatic test_npot();
    logic [1:0] exp_idx [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    req3 = 3'b111;
    rdy3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({vld3, oh3, idx3} !== {1'b1, 3'b001 << exp_idx[k], exp_idx[k]} || dut3.ptr_q > 2'd2) begin
        bad++;
        $display("FAIL n3_seq[%0d] got v=%0b oh=%b idx=%0d ptr=%0d want idx=%0d ptr<3",
                 k, vld3, oh3, idx3, dut3.ptr_q, exp_idx[k]);
      end
    end
    total++;
    if (dut3.ptr_q !== 2'd0) begin
      bad++;
      $display("FAIL n3_ptr_wrap got %0d want 0", dut3.ptr_q);
    end
  endtask

  task automatic test_fixed_and_idle();
    req0 = 4'b1110;
    rdy0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({vld0, oh0, idx0} !== {1'b1, 4'b0010, 2'd1}) begin
        bad++;
        $display("FAIL fixed[%0d] got v=%0b oh=%b idx=%0d want v=1 oh=0010 idx=1", k, vld0, oh0, idx0);
      end
    end
    req0 = 4'b0000;
    #1;
    total++;
    if (any0 !== 1'b0) begin
      bad++;
      $display("FAIL fixed_any_req got %0b want 0", any0);
    end
    step();
    total++;
    if ({vld0, oh0, idx0} !== {1'b0, 4'b0000, 2'd0}) begin
      bad++;
      $display("FAIL fixed_idle got v=%0b oh=%b idx=%0d want all 0", vld0, oh0, idx0);
    end
    req4 = 4'b0000;
    rdy4 = 1'b1;
    step();
    step();
    total++;
    if ({vld4, oh4, idx4, dut4.ptr_q, any4} !== {1'b0, 4'b0000, 2'd0, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL rr_idle_ptr got v=%0b oh=%b idx=%0d ptr=%0d any=%0b want v=0 oh=0 idx=0 ptr=1 any=0",
               vld4, oh4, idx4, dut4.ptr_q, any4);
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_wrap();
    test_npot();
    test_fixed_and_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
